// File: rtl/sym_buf_pkg.sv
// sym_buf_pkg: shared constants and read-FSM state type for the CP symbol buffer.
// Holds the default FFT size, the default cyclic-prefix length and the
// resulting on-air symbol length (NFFT + CP_LEN).
package sym_buf_pkg;
    localparam int NFFT_LOG2_DEF = 6;
    localparam int NFFT_DEF      = 1 << NFFT_LOG2_DEF;
    localparam int CP_LEN_DEF    = 16;
    localparam int SYM_LEN_DEF   = NFFT_DEF + CP_LEN_DEF;
    typedef enum logic [1:0] {RD_IDLE, RD_CP, RD_BODY} rd_state_t;
endpackage

// File: rtl/sym_buf_skid.sv
// sym_buf_skid: 2-entry output FIFO that absorbs the one-cycle RAM read latency.
// Ports: clk, rstn (sync, active-low); push/din write an entry;
// ready pops the head when valid; valid/dout expose the head; count is occupancy (0..2).
module sym_buf_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp, rp, pop;

    assign valid = count != 2'd0;
    assign pop   = valid && ready;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/sym_buf_ctrl.sv
// sym_buf_ctrl: ping-pong symbol buffer that re-emits each IFFT symbol with a cyclic prefix.
// Ports: clk, rstn (sync, active-low);
// in_data/in_valid/in_ready: natural-order time samples, 2^NFFT_LOG2 per symbol;
// out_data/out_valid/out_ready/out_last: CP + body stream, out_last on the final sample;
// ram_wea/ram_addra/ram_dia: write port of external dual-port RAM ({bank, index});
// ram_enb/ram_addrb/ram_dob: read port, data returns one cycle after ram_enb;
// bank_full: per-bank full flags (debug).
module sym_buf_ctrl
    import sym_buf_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
    parameter int CP_LEN    = CP_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DWIDTH-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DWIDTH-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 ram_wea,
    output logic [NFFT_LOG2:0]   ram_addra,
    output logic [DWIDTH-1:0]    ram_dia,
    output logic                 ram_enb,
    output logic [NFFT_LOG2:0]   ram_addrb,
    input  logic [DWIDTH-1:0]    ram_dob,
    output logic [1:0]           bank_full
);
    localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;
    localparam logic [NFFT_LOG2-1:0] CP_START = NFFT_LOG2'((1 << NFFT_LOG2) - CP_LEN);
    localparam logic [NFFT_LOG2-1:0] ONE      = NFFT_LOG2'(1);

    logic                 wr_bank, rd_bank;
    logic [NFFT_LOG2-1:0] wr_idx, rd_idx, cur_idx;
    rd_state_t            state, state_nxt;
    logic                 accept, issue, wrap, rd_done, room, pop;
    logic                 in_flight, in_flight_last;
    logic [1:0]           count;
    logic [DWIDTH:0]      head;

    assign in_ready  = !bank_full[wr_bank];
    assign accept    = in_valid && in_ready && rstn;
    assign ram_wea   = accept;
    assign ram_addra = accept ? {wr_bank, wr_idx} : '0;
    assign ram_dia   = in_data;

    // Occupancy plus outstanding read must stay below the skid depth once this cycle's pop leaves.
    assign pop  = out_valid && out_ready;
    assign room = ({1'b0, count} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop});

    // IDLE issues the first CP address itself so the first sample lands two edges after the bank fills.
    always_comb begin
        cur_idx   = (state == RD_IDLE) ? CP_START : rd_idx;
        wrap      = cur_idx == LAST_IDX;
        issue     = rstn && room && (state != RD_IDLE || bank_full[rd_bank]);
        rd_done   = issue && wrap && state == RD_BODY;
        state_nxt = !issue ? state :
                    wrap   ? ((state == RD_BODY) ? RD_IDLE : RD_BODY) :
                    ((state == RD_IDLE) ? RD_CP : state);
    end

    assign ram_enb   = issue;
    assign ram_addrb = issue ? {rd_bank, cur_idx} : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= RD_IDLE;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            bank_full      <= 2'b00;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_nxt;
            in_flight      <= issue;
            in_flight_last <= rd_done;
            if (issue) rd_idx <= cur_idx + ONE;
            if (accept) wr_idx <= wr_idx + ONE;
            // Writer only fills an empty bank and reader only frees a full one, so these never collide.
            if (accept && wr_idx == LAST_IDX) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (rd_done) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    // The last-sample tag travels with the read data through the skid.
    sym_buf_skid #(.W(DWIDTH + 1)) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_flight),
        .din   ({in_flight_last, ram_dob}),
        .ready (out_ready),
        .valid (out_valid),
        .dout  (head),
        .count (count)
    );

    assign out_data = head[DWIDTH-1:0];
    assign out_last = out_valid && head[DWIDTH];
endmodule

// File: tb/tb_sym_buf_ctrl.sv
// tb_sym_buf_ctrl: self-checking bench for sym_buf_ctrl (default build plus a CP_LEN=1 build).
module tb_sym_buf_ctrl;
    import sym_buf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [31:0] in_data, out_data, ram_dia, ram_dob;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, ram_wea, ram_enb;
    logic [6:0]  ram_addra, ram_addrb;
    logic [1:0]  bank_full;

    logic [31:0] in_data1, out_data1, ram_dia1, ram_dob1;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, ram_wea1, ram_enb1;
    logic [6:0]  ram_addra1, ram_addrb1;
    logic [1:0]  bank_full1;

    sym_buf_ctrl dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
        .bank_full(bank_full)
    );

    sym_buf_ctrl #(.CP_LEN(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
        .ram_wea(ram_wea1), .ram_addra(ram_addra1), .ram_dia(ram_dia1),
        .ram_enb(ram_enb1), .ram_addrb(ram_addrb1), .ram_dob(ram_dob1),
        .bank_full(bank_full1)
    );

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];
    always @(posedge clk) begin
        if (ram_wea) mem0[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem0[ram_addrb];
        if (ram_wea1) mem1[ram_addra1] <= ram_dia1;
        if (ram_enb1) ram_dob1 <= mem1[ram_addrb1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    logic [32:0] q[$];
    logic [32:0] e;
    logic        mon_en = 1'b0, force_stall = 1'b0, stall_prev = 1'b0, saw_bp = 1'b0;
    logic [31:0] prev_data;
    int          rdy_pct = 100, n_out = 0, n_last = 0, bubbles = 0, sym_pos = 0, stall_reads = 0;

    // Output monitor / scoreboard: drives out_ready mid-cycle, checks what is accepted at the next edge.
    always @(negedge clk) begin
        if (mon_en) out_ready = force_stall ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        #1;
        if (mon_en) begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_ready && sym_pos != 0 && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                check("queue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_last", out_last, e[32]);
                end
                n_out++;
                if (out_last) n_last++;
                sym_pos = out_last ? 0 : sym_pos + 1;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (!in_ready) saw_bp = 1'b1;
            if (force_stall && ram_enb) stall_reads++;
        end
    end

    task automatic clear_sb();
        n_out = 0; n_last = 0; bubbles = 0; saw_bp = 1'b0; sym_pos = 0; stall_prev = 1'b0;
    endtask

    // Feeds n symbols; expected CP+body sequence is queued before each symbol is driven.
    task automatic feed(input int n, input int vpct, input bit rnd, output int last_acc);
        logic [31:0] d [64];
        int k, g;
        last_acc = 0;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < NFFT_DEF; i++) d[i] = rnd ? $urandom : 32'(i);
            for (int i = NFFT_DEF - CP_LEN_DEF; i < NFFT_DEF; i++) q.push_back({1'b0, d[i]});
            for (int i = 0; i < NFFT_DEF; i++) q.push_back({(i == NFFT_DEF - 1), d[i]});
            k = 0;
            g = 0;
            while (k < NFFT_DEF && g < 5000) begin
                @(negedge clk);
                in_valid = ($urandom_range(0, 99) < vpct);
                in_data  = d[k];
                #1;
                if (in_valid && in_ready) begin
                    k++;
                    last_acc = cyc + 1;
                end
                g++;
            end
            check("feed_in_time", g < 5000, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check("drain_in_time", g < 20000, 1);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int nsym;
        int vld_pct;
        int rdy_pct;
        int exp_out;
        int exp_last;
        int exp_bp;
    } vec_t;
    vec_t vecs [4];

    initial begin
        int last_acc, g, n1;
        vecs[0] = '{3,  100, 100, 3 * SYM_LEN_DEF,  3,  1};
        vecs[1] = '{20, 70,  50,  20 * SYM_LEN_DEF, 20, -1};
        vecs[2] = '{4,  100, 30,  4 * SYM_LEN_DEF,  4,  1};
        vecs[3] = '{2,  40,  100, 2 * SYM_LEN_DEF,  2,  0};
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ram_wea", ram_wea, 0);
        check("rst_ram_enb", ram_enb, 0);
        check("rst_addra", ram_addra, 0);
        check("rst_addrb", ram_addrb, 0);
        check("rst_bank_full", bank_full, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Single ramp symbol: latency of first output and full CP+body order.
        clear_sb();
        rdy_pct = 100;
        mon_en = 1'b1;
        feed(1, 100, 0, last_acc);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("first_valid_latency", cyc - last_acc, 2);
        drain();
        check("ramp_n_out", n_out, SYM_LEN_DEF);
        check("ramp_n_last", n_last, 1);
        check("ramp_bubbles", bubbles, 0);

        for (int v = 0; v < 4; v++) begin
            clear_sb();
            rdy_pct = vecs[v].rdy_pct;
            feed(vecs[v].nsym, vecs[v].vld_pct, 1, last_acc);
            drain();
            check("vec_n_out", n_out, vecs[v].exp_out);
            check("vec_n_last", n_last, vecs[v].exp_last);
            check("vec_bubbles", bubbles, 0);
            if (vecs[v].exp_bp >= 0) check("vec_backpressure", saw_bp, vecs[v].exp_bp);
        end

        // Long stall in the middle of the cyclic prefix.
        clear_sb();
        rdy_pct = 100;
        feed(1, 100, 0, last_acc);
        g = 0;
        while (n_out < 8 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("reach_mid_cp", n_out, 8);
        stall_reads = 0;
        force_stall = 1'b1;
        repeat (100) @(negedge clk);
        force_stall = 1'b0;
        check("stall_reads_bounded", stall_reads <= 2, 1);
        drain();
        check("stall_n_out", n_out, SYM_LEN_DEF);

        // Reset while two symbols are buffered and the first is 30 samples out.
        clear_sb();
        rdy_pct = 0;
        feed(2, 100, 0, last_acc);
        rdy_pct = 100;
        g = 0;
        while (n_out < 30 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("reach_out30", n_out, 30);
        rstn = 1'b0;
        mon_en = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_ram_wea", ram_wea, 0);
        check("mid_rst_ram_enb", ram_enb, 0);
        check("mid_rst_addra", ram_addra, 0);
        check("mid_rst_addrb", ram_addrb, 0);
        check("mid_rst_bank_full", bank_full, 0);
        rstn = 1'b1;
        q.delete();
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        clear_sb();
        mon_en = 1'b1;
        feed(1, 100, 0, last_acc);
        drain();
        check("post_rst_n_out", n_out, SYM_LEN_DEF);
        check("post_rst_n_last", n_last, 1);
        mon_en = 1'b0;

        // CP_LEN=1 build: expect 63 then 0..63, last on the 65th sample.
        for (int k = 0; k < NFFT_DEF; k++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 32'(k);
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        n1 = 0;
        g = 0;
        while (n1 < NFFT_DEF + 1 && g < 300) begin
            if (out_valid1) begin
                check("cp1_data", out_data1, (n1 == 0) ? 63 : n1 - 1);
                check("cp1_last", out_last1, n1 == NFFT_DEF);
                n1++;
            end
            @(negedge clk);
            g++;
        end
        check("cp1_count", n1, NFFT_DEF + 1);
        repeat (5) @(negedge clk);
        check("cp1_no_extra", out_valid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/sym_buf_ctrl.md
SYM_BUF_CTRL -- requirements
Module: sym_buf_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, sample width (I16:Q16).
REQ-002 SHALL have parameter NFFT_LOG2, default 6, log2 of symbol length (64 samples).
REQ-003 SHALL have parameter CP_LEN, default 16, cyclic-prefix length in samples, 1..2^NFFT_LOG2-1.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports in_data/in_valid/in_ready  in/in/out  DWIDTH/1/1  frequency-domain-to-time sample stream from IFFT, natural order.
REQ-007 SHALL have ports out_data/out_valid/out_ready/out_last  out/out/in/out  DWIDTH/1/1/1  CP-prefixed symbol stream; out_last marks sample 80 of 80.
REQ-008 SHALL have ports ram_wea, ram_addra, ram_dia  out  1, NFFT_LOG2+1, DWIDTH  write port of external dual-port RAM (bank bit = MSB).
REQ-009 SHALL have ports ram_enb, ram_addrb, ram_dob  out/out/in  1, NFFT_LOG2+1, DWIDTH  read port; ram_dob valid one cycle after ram_enb.
REQ-010 SHALL have port bank_full  out  2  per-bank full flags, for debug.

Function
REQ-011 Write side SHALL accept a sample when in_valid&&in_ready, driving ram_wea=1, ram_addra={wr_bank,wr_idx}, ram_dia=in_data in that cycle.
REQ-012 in_ready SHALL equal !bank_full[wr_bank] (combinational only from registers).
REQ-013 wr_idx SHALL increment per accepted sample, wrapping 63->0; on wrap bank_full[wr_bank] SHALL set and wr_bank toggle.
REQ-014 Read FSM states: IDLE, CP, BODY; IDLE->CP when bank_full[rd_bank]; CP issues addresses 64-CP_LEN..63; BODY issues 0..63; after last BODY issue -> DRAIN-free return to IDLE.
REQ-015 A read SHALL be issued (ram_enb=1) only if skid occupancy + reads in flight - pop this cycle < 2.
REQ-016 Returned ram_dob SHALL be captured into a 2-entry output skid FIFO; out_valid = FIFO non-empty; out_data = FIFO head.
REQ-017 out_last SHALL assert with the 80th sample (64+CP_LEN) of each symbol only.
REQ-018 bank_full[rd_bank] SHALL clear and rd_bank toggle on the cycle the last BODY read is issued.
REQ-019 Set of one bank and clear of the other in the same cycle SHALL both take effect.
REQ-020 With out_ready held high and both banks supplied, output SHALL sustain 1 sample/clk within a symbol.
REQ-021 out_valid SHALL first rise 2 edges after the edge accepting the 64th input sample (idle reader).
REQ-022 out_valid SHALL not drop while out_ready=0; out_data SHALL hold stable until accepted.
REQ-023 Symbols SHALL be emitted in input order; no sample loss or duplication under arbitrary valid/ready patterns.

Reset
REQ-024 While rstn=0 at a clk edge: wr_bank, rd_bank, wr_idx, FSM=IDLE, bank_full=0, skid empty, in-flight=0.
REQ-025 During and after reset: out_valid=0, out_last=0, ram_wea=0, ram_enb=0, addresses 0; in_ready=1 from first cycle after release.
REQ-026 Reset mid-symbol SHALL discard both banks' contents; ram_dob returning after reset SHALL be ignored.

Structure
REQ-027 Package sym_buf_pkg SHALL hold NFFT, CP_LEN defaults, symbol length constant (NFFT+CP_LEN) and the read FSM state enum.
REQ-028 The 2-entry output FIFO SHALL be a sub-module sym_buf_skid; RAM remains external.

Verification
REQ-029 Feed 64 samples 0..63 back-to-back, out_ready=1 -> out 48..63,0..63 contiguous, out_last on 80th, out_valid rises 2 edges after 64th accept.
REQ-030 Feed 3 symbols continuously -> in_ready drops after symbol 2 fills, reasserts as bank 0 frees; 240 outputs in order, no bubbles within a symbol.
REQ-031 Random out_ready (50%) and in_valid (70%) for 20 symbols -> scoreboard match, out_data stable while stalled.
REQ-032 out_ready=0 for 100 cycles mid-CP -> at most 2 reads outstanding, no loss, resume at next address.
REQ-033 Assert rstn=0 at sample 30 of output -> all outputs per REQ-025 next cycle; fresh symbol 0..63 afterwards emits 48..63,0..63.
REQ-034 CP_LEN=1 build -> output 63,0..63, out_last on 65th sample.
